// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one BLOCK-bit slice per clock with the
// inter-slice carry held in a register. Reports unsigned borrow-out and signed overflow.
module block_serial_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             of
);

  localparam int unsigned NumBlk = WIDTH / BLOCK;
  localparam int unsigned CntW   = (NumBlk > 1) ? $clog2(NumBlk) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBlk - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, bout_q, bout_d, of_q, of_d;

  logic             accept, last;
  logic [31:0]      base;
  logic [BLOCK-1:0] a_slice, b_slice;
  logic [BLOCK:0]   slice_sum;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (state_q == StCalc) && (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last) state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StCalc);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
    of   = of_q;
  end

  // Subtraction as a + ~b + ~bin; the carry out of each slice is the inverted borrow.
  always_comb begin
    base      = 32'(cnt_q) * BLOCK;
    a_slice   = a_q[base +: BLOCK];
    b_slice   = b_q[base +: BLOCK];
    slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{BLOCK{1'b0}}, carry_q};

    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    of_d    = of_q;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      carry_d = ~bin;
    end else if (state_q == StCalc) begin
      diff_d[base +: BLOCK] = slice_sum[BLOCK-1:0];
      carry_d               = slice_sum[BLOCK];
      cnt_d                 = cnt_q + CntW'(1);
      if (last) begin
        bout_d = ~slice_sum[BLOCK];
        of_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_sum[BLOCK-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      of_q    <= of_d;
    end
  end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Bench for block_serial_subtractor: three instances (BLOCK = 8, 4, 32) share stimulus and
// are compared against an arithmetic reference model, plus directed handshake/reset cases.
module tb_block_serial_subtractor;

  localparam int MaxWait = 12;

  logic        clk, rst, start, bin;
  logic [31:0] a, b;
  logic [2:0]  busy_w, done_w, bout_w, of_w;
  logic [31:0] diff_w [3];

  int errors = 0;
  int checks = 0;

  int busy_cnt [3];
  int done_cnt [3];
  int done_at  [3];
  logic [31:0] res_diff [3];
  logic        res_bout [3];
  logic        res_of   [3];

  block_serial_subtractor #(.WIDTH(32), .BLOCK(8)) u_dut_b8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy_w[0]), .done(done_w[0]), .diff(diff_w[0]), .bout(bout_w[0]), .of(of_w[0])
  );

  block_serial_subtractor #(.WIDTH(32), .BLOCK(4)) u_dut_b4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy_w[1]), .done(done_w[1]), .diff(diff_w[1]), .bout(bout_w[1]), .of(of_w[1])
  );

  block_serial_subtractor #(.WIDTH(32), .BLOCK(32)) u_dut_b32 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy_w[2]), .done(done_w[2]), .diff(diff_w[2]), .bout(bout_w[2]), .of(of_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int blk_of(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, unsigned for borrow and signed for overflow.
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi,
                                  output logic [31:0] d, output logic bo, output logic o);
    logic [32:0] full;
    longint      s;
    full = {1'b0, x} - {1'b0, y} - {32'b0, bi};
    d    = full[31:0];
    bo   = ({32'b0, x} < ({32'b0, y} + {32'b0, bi}));
    s    = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
    o    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                        input string tag);
    logic [31:0] ed;
    logic        eb, eo;
    ref_sub(av, bv, bi, ed, eb, eo);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
    end
    for (int c = 1; c <= MaxWait; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) busy_cnt[i]++;
        if (done_w[i]) begin
          done_cnt[i]++;
          done_at[i]  = c;
          res_diff[i] = diff_w[i];
          res_bout[i] = bout_w[i];
          res_of[i]   = of_w[i];
        end
      end
      if (c != MaxWait) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      int nb;
      nb = 32 / blk_of(i);
      check_eq($sformatf("%s_b%0d_busy_cycles", tag, blk_of(i)), 64'(busy_cnt[i]), 64'(nb));
      check_eq($sformatf("%s_b%0d_done_count", tag, blk_of(i)), 64'(done_cnt[i]), 64'd1);
      check_eq($sformatf("%s_b%0d_done_cycle", tag, blk_of(i)), 64'(done_at[i]), 64'(nb + 1));
      check_eq($sformatf("%s_b%0d_diff", tag, blk_of(i)), 64'(res_diff[i]), 64'(ed));
      check_eq($sformatf("%s_b%0d_bout", tag, blk_of(i)), 64'(res_bout[i]), 64'(eb));
      check_eq($sformatf("%s_b%0d_of", tag, blk_of(i)), 64'(res_of[i]), 64'(eo));
    end
  endtask

  task automatic check_spec(input string tag, input logic [31:0] d, input logic bo,
                            input logic o);
    check_eq({tag, "_diff_const"}, 64'(res_diff[0]), 64'(d));
    check_eq({tag, "_bout_const"}, 64'(res_bout[0]), 64'(bo));
    check_eq({tag, "_of_const"}, 64'(res_of[0]), 64'(o));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset_b%0d_busy", blk_of(i)), 64'(busy_w[i]), 64'd0);
      check_eq($sformatf("reset_b%0d_done", blk_of(i)), 64'(done_w[i]), 64'd0);
      check_eq($sformatf("reset_b%0d_diff", blk_of(i)), 64'(diff_w[i]), 64'd0);
      check_eq($sformatf("reset_b%0d_bout", blk_of(i)), 64'(bout_w[i]), 64'd0);
      check_eq($sformatf("reset_b%0d_of", blk_of(i)), 64'(of_w[i]), 64'd0);
    end
    rst = 1'b0;

    run_op(32'd5, 32'd3, 1'b0, "t5m3");
    check_spec("t5m3", 32'h0000_0002, 1'b0, 1'b0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, "slice_borrow");
    check_spec("slice_borrow", 32'h0000_00FF, 1'b0, 1'b0);
    run_op(32'h0, 32'h0, 1'b1, "full_ripple");
    check_spec("full_ripple", 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h1, 1'b0, "ovf_neg");
    check_spec("ovf_neg", 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ovf_pos");
    check_spec("ovf_pos", 32'h8000_0000, 1'b1, 1'b1);

    // Start held high through an op: second op is taken in the DONE cycle; a start
    // pulse during the second CALC must be ignored.
    @(negedge clk);
    a = 32'd5; b = 32'd3; bin = 1'b0; start = 1'b1;
    dn = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (done_w[0]) begin
        dn++;
        if (dn == 1) begin
          check_eq("b2b_first_cycle", 64'(c), 64'd5);
          check_eq("b2b_first_diff", 64'(diff_w[0]), 64'd2);
        end else if (dn == 2) begin
          check_eq("b2b_second_cycle", 64'(c), 64'd10);
          check_eq("b2b_second_diff", 64'(diff_w[0]), 64'd6);
        end
      end
      if (c == 2) begin a = 32'd10; b = 32'd4; end
      if (c == 6) start = 1'b0;
      if (c == 8) begin start = 1'b1; a = 32'd100; end
      if (c == 9) start = 1'b0;
    end
    check_eq("b2b_done_count", 64'(dn), 64'd2);

    // Reset asserted in the second busy cycle clears outputs without waiting for a clock.
    @(negedge clk);
    a = 32'd0; b = 32'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy_before", 64'(busy_w[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("midrst_b%0d_busy", blk_of(i)), 64'(busy_w[i]), 64'd0);
      check_eq($sformatf("midrst_b%0d_done", blk_of(i)), 64'(done_w[i]), 64'd0);
      check_eq($sformatf("midrst_b%0d_diff", blk_of(i)), 64'(diff_w[i]), 64'd0);
      check_eq($sformatf("midrst_b%0d_bout", blk_of(i)), 64'(bout_w[i]), 64'd0);
      check_eq($sformatf("midrst_b%0d_of", blk_of(i)), 64'(of_w[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < MaxWait; c++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) dn++;
    end
    check_eq("midrst_no_activity", 64'(dn), 64'd0);
    run_op(32'd9, 32'd9, 1'b0, "t9m9");
    check_spec("t9m9", 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      run_op(pick(), pick(), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_serial_subtractor.md
Name: block_serial_subtractor

Overview:
- Multi-cycle 32-bit subtractor computing diff = a - b - bin, with borrow-out and signed-overflow flags.
- Datapath processes one BLOCK-bit slice per clock and carries the borrow between slices in a register.
- Complements the single-cycle 32-bit adder datapath; intended for the ALU subtract path where area matters more than latency.
- start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 32, operand and result width.
- BLOCK, 8, slice width per cycle; WIDTH must be an integer multiple of BLOCK; NBLK = WIDTH/BLOCK.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- of  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, of = 0.
  - Slice counter and internal borrow are cleared.
  - Reset asserted mid-operation aborts the operation; nothing is reported.
- States:
  - IDLE: busy=0, done=0. start=1 → capture a, b, bin; counter = 0; go to CALC.
  - CALC: busy=1. Each cycle computes slice k = counter as a_k + ~b_k + carry, where the initial carry is ~bin. Writes diff[k*BLOCK +: BLOCK]; the carry register takes the slice carry-out; counter increments.
    - On the cycle counter = NBLK-1: latch bout = ~final carry and of per the port formula, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 → capture and go to CALC (back-to-back, no bubble). start=0 → IDLE.
- Latency: start sampled at edge E → busy high for cycles E+1..E+NBLK → done high in cycle E+NBLK+1. Default is 4 busy cycles, done in the 5th cycle.
- start while in CALC is ignored. Captured operands are unaffected by input changes after capture.
- Output holding:
  - diff, bout, of hold their last completed values until the next operation's DONE.
  - diff slices may update during CALC; the bench checks diff only when done=1.
  - bout and of change only on the final CALC edge.
- Borrow crossing slice boundaries must propagate correctly, including a full ripple through all NBLK slices.
- No combinational path from inputs to outputs.

Test Plan:
- a=5, b=3, bin=0, start pulse → done 5 cycles after the start edge; diff=0x00000002, bout=0, of=0; busy high for exactly 4 cycles.
- a=0x00000100, b=0x00000001 (borrow crosses slice 0→1) → diff=0x000000FF, bout=0, of=0. Then a=0, b=0, bin=1 (full ripple) → diff=0xFFFFFFFF, bout=1, of=0.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, bout=0, of=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, bout=1, of=1.
- Back-to-back and ignored starts:
  - start held high through op (5-3), with inputs changed to (10-4) during CALC → first done reports 2; second op accepted in the DONE cycle → next done reports 6.
  - No extra operation is started by start pulses seen during CALC.
- Reset mid-op:
  - Start (0-1), assert rst in the 2nd busy cycle → busy, done, diff, bout, of all 0 immediately (asynchronously, before next edge).
  - After release, no done pulse occurs until a new start; a new (9-9) op then gives diff=0, bout=0, of=0.
- Parameter sweep with BLOCK=4 and BLOCK=32: random 1000-vector compare against a reference model; latency = NBLK busy cycles + 1 done cycle.
